// File: rtl/alu_cdb_unit.sv
// Integer execution unit: RV32I ALU plus branch/jump resolution, feeding a
// small result FIFO that requests the common data bus with request/grant.

package alu_cdb_pkg;
  // Opcode encodings shared with the reservation station.
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_SLTIU = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_ORI   = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd16;
  localparam logic [5:0] OP_SLLI  = 6'd17;
  localparam logic [5:0] OP_SRLI  = 6'd18;
  localparam logic [5:0] OP_SRAI  = 6'd19;
  localparam logic [5:0] OP_ADD   = 6'd20;
  localparam logic [5:0] OP_SUB   = 6'd21;
  localparam logic [5:0] OP_SLL   = 6'd22;
  localparam logic [5:0] OP_SLT   = 6'd23;
  localparam logic [5:0] OP_SLTU  = 6'd24;
  localparam logic [5:0] OP_XOR   = 6'd25;
  localparam logic [5:0] OP_SRL   = 6'd26;
  localparam logic [5:0] OP_SRA   = 6'd27;
  localparam logic [5:0] OP_OR    = 6'd28;
  localparam logic [5:0] OP_AND   = 6'd29;
endpackage

module alu_cdb_unit
  import alu_cdb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [OP_W-1:0]  rs_opcode,
  input  logic [XLEN-1:0]  rs_vj,
  input  logic [XLEN-1:0]  rs_vk,
  input  logic [XLEN-1:0]  rs_a,
  input  logic [XLEN-1:0]  rs_pc,
  input  logic [ROB_W-1:0] rs_rob_pos,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [ROB_W-1:0] cdb_rob_pos,
  output logic [XLEN-1:0]  cdb_val,
  output logic             cdb_jump,
  output logic [XLEN-1:0]  cdb_target
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SH_W  = $clog2(XLEN);

  typedef struct packed {
    logic [ROB_W-1:0] rob_pos;
    logic [XLEN-1:0]  val;
    logic             jump;
    logic [XLEN-1:0]  target;
  } result_t;

  result_t          mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  result_t          res;
  logic             push;
  logic             pop;
  logic [SH_W-1:0]  sh_reg;
  logic [SH_W-1:0]  sh_imm;
  logic [XLEN-1:0]  jalr_sum;
  logic             br_cond;

  assign rs_ready  = !rst && (count < (PTR_W+1)'(DEPTH));
  assign cdb_valid = !rst && (count != '0);

  // Flush and reset win over both handshakes; rdy gates everything else.
  assign push = rs_valid && rs_ready && rdy && !flush && !rst;
  assign pop  = cdb_valid && cdb_grant && rdy && !flush && !rst;

  assign sh_reg   = rs_vk[SH_W-1:0];
  assign sh_imm   = rs_a[SH_W-1:0];
  assign jalr_sum = rs_vj + rs_a;

  // Branch condition evaluation for the six conditional branches.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    br_cond = 1'b0;
    case (rs_opcode)
      OP_BEQ:  br_cond = (rs_vj == rs_vk);
      OP_BNE:  br_cond = (rs_vj != rs_vk);
      OP_BLT:  br_cond = ($signed(rs_vj) <  $signed(rs_vk));
      OP_BGE:  br_cond = ($signed(rs_vj) >= $signed(rs_vk));
      OP_BLTU: br_cond = (rs_vj <  rs_vk);
      OP_BGEU: br_cond = (rs_vj >= rs_vk);
      default: br_cond = 1'b0;
    endcase
  end

  // Result, jump flag and redirect target for the incoming entry.
  always_comb begin
    res         = '0;
    res.rob_pos = rs_rob_pos;
    case (rs_opcode)
      OP_LUI:   res.val = rs_a;
      OP_AUIPC: res.val = rs_pc + rs_a;
      OP_ADD:   res.val = rs_vj + rs_vk;
      OP_SUB:   res.val = rs_vj - rs_vk;
      OP_AND:   res.val = rs_vj & rs_vk;
      OP_OR:    res.val = rs_vj | rs_vk;
      OP_XOR:   res.val = rs_vj ^ rs_vk;
      OP_SLL:   res.val = rs_vj << sh_reg;
      OP_SRL:   res.val = rs_vj >> sh_reg;
      OP_SRA:   res.val = $unsigned($signed(rs_vj) >>> sh_reg);
      OP_ADDI:  res.val = rs_vj + rs_a;
      OP_ANDI:  res.val = rs_vj & rs_a;
      OP_ORI:   res.val = rs_vj | rs_a;
      OP_XORI:  res.val = rs_vj ^ rs_a;
      OP_SLLI:  res.val = rs_vj << sh_imm;
      OP_SRLI:  res.val = rs_vj >> sh_imm;
      OP_SRAI:  res.val = $unsigned($signed(rs_vj) >>> sh_imm);
      OP_SLT:   res.val = XLEN'($signed(rs_vj) < $signed(rs_vk));
      OP_SLTI:  res.val = XLEN'($signed(rs_vj) < $signed(rs_a));
      OP_SLTU:  res.val = XLEN'(rs_vj < rs_vk);
      OP_SLTIU: res.val = XLEN'(rs_vj < rs_a);
      OP_JAL: begin
        res.val    = rs_pc + XLEN'(4);
        res.jump   = 1'b1;
        res.target = rs_pc + rs_a;
      end
      OP_JALR: begin
        res.val    = rs_pc + XLEN'(4);
        res.jump   = 1'b1;
        res.target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res.jump   = br_cond;
        res.target = rs_pc + rs_a;
      end
      default: ;
    endcase
  end

  // FIFO storage write at the tail.
  // NOTE: the data array has no reset; validity is tracked solely by count, so resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= res;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign cdb_rob_pos = cdb_valid ? mem[head].rob_pos : '0;
  assign cdb_val     = cdb_valid ? mem[head].val     : '0;
  assign cdb_jump    = cdb_valid ? mem[head].jump    : 1'b0;
  assign cdb_target  = cdb_valid ? mem[head].target  : '0;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Scoreboard bench for alu_cdb_unit: stimulus pushes expected CDB results,
// an independent monitor pops and compares at every accepted grant.

module tb_alu_cdb_unit;
  import alu_cdb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, rs_valid, rs_ready;
  logic [5:0]  rs_opcode;
  logic [31:0] rs_vj, rs_vk, rs_a, rs_pc;
  logic [3:0]  rs_rob_pos;
  logic        cdb_valid, cdb_grant, cdb_jump;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val, cdb_target;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  alu_cdb_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_opcode(rs_opcode),
    .rs_vj(rs_vj), .rs_vk(rs_vk), .rs_a(rs_a), .rs_pc(rs_pc),
    .rs_rob_pos(rs_rob_pos),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_rob_pos(cdb_rob_pos),
    .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_target(cdb_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever this holds mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !flush && rdy && cdb_grant && cdb_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_broadcast", {28'd0, cdb_rob_pos}, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cdb_rob_pos", {28'd0, cdb_rob_pos}, {28'd0, e.rob});
          check("cdb_val", cdb_val, e.val);
          check("cdb_jump", {31'd0, cdb_jump}, {31'd0, e.jump});
          check("cdb_target", cdb_target, e.target);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry, wait (bounded) for ready, record expectation at acceptance.
  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] a, input logic [31:0] pc, input logic [3:0] rob,
                       input logic [31:0] ev, input logic ej, input logic [31:0] et);
    exp_t e;
    int   n;
    rs_opcode = op; rs_vj = vj; rs_vk = vk; rs_a = a; rs_pc = pc; rs_rob_pos = rob;
    rs_valid  = 1'b1;
    n = 0;
    while (!rs_ready && n < 20) begin
      tick();
      n++;
    end
    if (!rs_ready) check("issue_ready_timeout", 32'd0, 32'd1);
    e.rob = rob; e.val = ev; e.jump = ej; e.target = et;
    sb.push_back(e);
    tick();
    rs_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    cdb_grant = 1'b1;
    n = 0;
    while ((sb.size() != 0 || cdb_valid) && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", {31'd0, cdb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; rs_valid = 1'b0; cdb_grant = 1'b0;
    rs_opcode = '0; rs_vj = '0; rs_vk = '0; rs_a = '0; rs_pc = '0; rs_rob_pos = '0;
    tick(); tick();
    check("reset_rs_ready", {31'd0, rs_ready}, 32'd0);
    check("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_ready", {31'd0, rs_ready}, 32'd1);

    // Basic ADD with single-cycle latency, then grant.
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b0, 32'd0);
    check("add_latency_valid", {31'd0, cdb_valid}, 32'd1);
    check("add_head_val", cdb_val, 32'd12);
    cdb_grant = 1'b1;
    tick();
    check("add_popped_valid", {31'd0, cdb_valid}, 32'd0);
    check("empty_val_zero", cdb_val, 32'd0);
    cdb_grant = 1'b0;

    // Fill the FIFO with grant held low.
    for (int i = 0; i < 4; i++)
      issue(OP_ADDI, i, 32'd0, 32'd1, 32'd0, 4'(i), i + 1, 1'b0, 32'd0);
    check("full_ready_low", {31'd0, rs_ready}, 32'd0);
    tick();
    check("full_head_stable", cdb_val, 32'd1);
    check("full_rob_stable", {28'd0, cdb_rob_pos}, 32'd0);
    cdb_grant = 1'b1;
    tick();
    check("ready_after_pop", {31'd0, rs_ready}, 32'd1);
    drain();

    // Arithmetic and branch corner cases, back to back with grant held.
    issue(OP_SRA,   32'h8000_0000, 32'h24, 0, 0, 4'd1, 32'hF800_0000, 0, 0);
    issue(OP_SLTU,  32'hFFFF_FFFF, 32'd1,  0, 0, 4'd2, 32'd0, 0, 0);
    issue(OP_SLT,   32'hFFFF_FFFF, 32'd1,  0, 0, 4'd3, 32'd1, 0, 0);
    issue(OP_BNE,   32'd1, 32'd2, 32'h20, 32'h100, 4'd4, 32'd0, 1, 32'h120);
    issue(OP_JALR,  32'h1003, 0, 32'd2, 32'h40, 4'd5, 32'h44, 1, 32'h1004);
    issue(OP_SUB,   32'd3, 32'd5, 0, 0, 4'd6, 32'hFFFF_FFFE, 0, 0);
    issue(OP_SLLI,  32'd1, 0, 32'h21, 0, 4'd7, 32'd2, 0, 0);
    issue(OP_SRLI,  32'h8000_0000, 0, 32'd31, 0, 4'd8, 32'd1, 0, 0);
    issue(OP_LUI,   0, 0, 32'h1234_5000, 0, 4'd9, 32'h1234_5000, 0, 0);
    issue(OP_AUIPC, 0, 0, 32'h2000, 32'h1000, 4'd10, 32'h3000, 0, 0);
    issue(OP_BGE,   32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 4'd11, 32'd0, 0, 32'h210);
    issue(OP_BLTU,  32'd1, 32'hFFFF_FFFF, 32'h10, 32'h200, 4'd12, 32'd0, 1, 32'h210);
    issue(OP_JAL,   0, 0, 32'hFFFF_FFF0, 32'h80, 4'd13, 32'h84, 1, 32'h70);
    issue(OP_XORI,  32'hF0F0, 0, 32'hFF, 0, 4'd14, 32'hF00F, 0, 0);
    issue(6'd63,    32'd9, 32'd9, 32'd9, 32'd9, 4'd15, 32'd0, 0, 0);
    drain();

    // Flush with a pending push and grant: everything is discarded.
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(OP_ADD, i, 32'd100, 0, 0, 4'(i), i + 100, 1'b0, 32'd0);
    rs_opcode = OP_ADD; rs_vj = 32'd7; rs_vk = 32'd7; rs_rob_pos = 4'd9;
    rs_valid = 1'b1; cdb_grant = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; rs_valid = 1'b0;
    sb.delete();
    check("flush_valid_low", {31'd0, cdb_valid}, 32'd0);
    check("flush_ready_high", {31'd0, rs_ready}, 32'd1);
    tick(); tick();
    check("flush_nothing_later", {31'd0, cdb_valid}, 32'd0);

    // rdy low freezes everything for three cycles.
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 0, 0, 4'd5, 32'd2, 1'b0, 32'd0);
    rdy = 1'b0; cdb_grant = 1'b1;
    rs_opcode = OP_ADDI; rs_vj = 32'd40; rs_a = 32'd2; rs_rob_pos = 4'd6; rs_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frozen_valid", {31'd0, cdb_valid}, 32'd1);
      check("frozen_val", cdb_val, 32'd2);
      check("frozen_rob", {28'd0, cdb_rob_pos}, 32'd5);
    end
    begin
      exp_t e;
      e.rob = 4'd6; e.val = 32'd42; e.jump = 1'b0; e.target = 32'd0;
      sb.push_back(e);
    end
    rdy = 1'b1;
    tick();
    rs_valid = 1'b0;
    check("resume_head_second", cdb_val, 32'd42);
    drain();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
